// File: rtl/pixel_result_packer_pkg.sv
// Shared types and constants for the pixel result packer and its output FIFO.
// The iteration step is shared with the upstream counter stage.
package pixel_result_packer_pkg;

  localparam int unsigned ITER_W  = 24;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned COORD_W = 16;
  localparam int unsigned IDX_W   = 8;
  localparam int unsigned ENTRY_W = RGB_W + 2;

  localparam logic [ITER_W-1:0] ITER_STEP = 24'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  typedef struct packed {
    logic             tuser;
    logic             tlast;
    logic [RGB_W-1:0] rgb;
  } pix_entry_t;

  // Palette: red ramps with the index, green ramps twice as fast, blue falls.
  function automatic logic [RGB_W-1:0] rgb_from_idx(input logic [IDX_W-1:0] idx);
    return {idx, idx[IDX_W-2:0], 1'b0, 8'hFF - idx};
  endfunction

endpackage

// File: rtl/pixel_result_packer_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// A pop never frees space for a push in the same cycle because full is registered.
module pixel_out_fifo #(
  parameter int unsigned DATA_W = 26,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              aclk,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge aclk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pixel_result_packer.sv
// Captures each terminated pixel's iteration count, maps it to RGB, queues it
// for AXI4-Stream output and sequences the raster and counter-stage restarts.
module pixel_result_packer
  import pixel_result_packer_pkg::*;
#(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned COLOUR_SHIFT = 2
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ITER_W-1:0] max_iterations,
  input  logic [ITER_W-1:0] iter_count,
  input  logic              iter_done,
  output logic              clr,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic              busy,
  output logic              frame_done,
  output logic [RGB_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  state_t             state;
  state_t             state_next;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_c;
  logic [ENTRY_W-1:0] fifo_head_c;
  pix_entry_t         entry_c;
  pix_entry_t         head_c;
  logic [COORD_W-1:0] pix_x_next;
  logic [COORD_W-1:0] pix_y_next;
  logic               frame_done_next;
  logic               at_last_x;
  logic               at_last_pix;

  logic [ITER_W:0]     sum_c;
  logic                in_set_c;
  logic [ITER_W-1:0]   shifted_c;
  logic [IDX_W-1:0]    idx_c;
  logic [RGB_W-1:0]    rgb_c;

  assign at_last_x   = (pix_x == X_LAST);
  assign at_last_pix = at_last_x && (pix_y == Y_LAST);

  // Classification in 25-bit arithmetic so count + step cannot wrap.
  always_comb begin
    sum_c     = {1'b0, iter_count} + {1'b0, ITER_STEP};
    in_set_c  = (sum_c > {1'b0, max_iterations});
    shifted_c = iter_count >> COLOUR_SHIFT;
    idx_c     = (|shifted_c[ITER_W-1:IDX_W]) ? 8'hFF : shifted_c[IDX_W-1:0];
    rgb_c     = in_set_c ? '0 : rgb_from_idx(idx_c);
  end

  always_comb begin
    entry_c       = '0;
    entry_c.tuser = (pix_x == '0) && (pix_y == '0);
    entry_c.tlast = at_last_x;
    entry_c.rgb   = rgb_c;
  end

  // State register plus the registered outputs that follow the next state.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state      <= ST_IDLE;
      clr        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
    end else begin
      state      <= state_next;
      clr        <= (state_next == ST_IDLE) || (state_next == ST_CLEAR);
      busy       <= (state_next != ST_IDLE);
      frame_done <= frame_done_next;
      pix_x      <= pix_x_next;
      pix_y      <= pix_y_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_RUN;
      ST_RUN:   if (iter_done) state_next = fifo_full ? ST_HOLD : ST_CLEAR;
      ST_HOLD:  if (!fifo_full) state_next = ST_CLEAR;
      ST_CLEAR: state_next = at_last_pix ? ST_IDLE : ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    push_c          = 1'b0;
    pix_x_next      = pix_x;
    pix_y_next      = pix_y;
    frame_done_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pix_x_next = '0;
          pix_y_next = '0;
        end
      end
      ST_RUN:  push_c = iter_done && !fifo_full;
      ST_HOLD: push_c = !fifo_full;
      ST_CLEAR: begin
        frame_done_next = at_last_pix;
        if (at_last_x) begin
          pix_x_next = '0;
          pix_y_next = at_last_pix ? '0 : pix_y + COORD_W'(1);
        end else begin
          pix_x_next = pix_x + COORD_W'(1);
        end
      end
      default: push_c = 1'b0;
    endcase
  end

  pixel_out_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .flush     (aresetn),
    .push      (push_c),
    .wr_data   (entry_c),
    .pop       (m_axis_tready),
    .rd_data_c (fifo_head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_c        = pix_entry_t'(fifo_head_c);
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = head_c.rgb;
  assign m_axis_tlast  = head_c.tlast;
  assign m_axis_tuser  = head_c.tuser;

endmodule

// File: doc/pixel_result_packer.md
Name: pixel_result_packer

Overview:
- Sits directly downstream of the iteration counter stage in the pipelined fractal accelerator.
- Watches the counter stage's done flag and, once a pixel terminates, captures the final iteration count and maps it to a 24-bit RGB colour.
- Pushes that colour into a small output FIFO drained over an AXI4-Stream master port, then pulses clr to restart the counter stage for the next pixel.
- Owns the raster position (pix_x, pix_y) that the upstream coordinate generator consumes.

Parameters:
- WIDTH, 640, pixels per line (≥2)
- HEIGHT, 480, lines per frame (≥1)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)
- COLOUR_SHIFT, 2, right-shift applied to the iteration count before colour mapping

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  synchronous, active-high reset (despite the name: asserted = 1)
- start  in  1  one-cycle pulse that begins a frame; ignored unless state is IDLE
- max_iterations  in  24  same value driven to the counter stage
- iter_count  in  24  counter output of the iteration stage
- iter_done  in  1  or_out of the iteration stage (diverged or overflowed)
- clr  out  1  restart/hold-in-reset for the iteration stage
- pix_x  out  16  current pixel column
- pix_y  out  16  current pixel row
- busy  out  1  high while state != IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is written to the FIFO
- m_axis_tdata  out  24  {R,G,B}
- m_axis_tvalid  out  1  FIFO non-empty
- m_axis_tready  in  1  downstream accept
- m_axis_tlast  out  1  last pixel of a line
- m_axis_tuser  out  1  first pixel of a frame

Behaviour:
- Reset, also when asserted mid-frame:
  - state = IDLE, clr = 1, pix_x = pix_y = 0, busy = 0, frame_done = 0.
  - FIFO is flushed; m_axis_tvalid = 0 from the next cycle.
  - tdata, tlast and tuser read 0.
- State machine (registered state and clr):
  - IDLE: clr = 1. On start go to RUN, with pix_x = pix_y = 0.
  - RUN: clr = 0.
    - If iter_done = 1 and the FIFO is not full: write the FIFO entry at this edge and go to CLEAR.
    - If iter_done = 1 and the FIFO is full: go to HOLD.
    - If iter_done = 0: stay in RUN.
  - HOLD: clr = 0; the iteration stage stays latched in DIVERGED/OVERFLOWED. When the FIFO is not full, write the entry and go to CLEAR.
  - CLEAR: clr = 1 for exactly one cycle, and pix_x/pix_y advance at the end of it.
    - If this was not the last pixel, go to RUN.
    - If it was the last pixel (pix_x = WIDTH-1, pix_y = HEIGHT-1): pulse frame_done in the cycle after CLEAR, then go to IDLE.
- Latency: with iter_done sampled high in RUN at cycle N and the FIFO empty:
  - tvalid rises in N+1.
  - clr = 1 in N+1.
  - The next pixel's RUN starts at N+2.
  - iter_done is guaranteed low at N+2 because the counter stage resets at the N+1 edge.
- Classification, computed at the capture edge:
  - in_set = (iter_count + 24'd4 > max_iterations), evaluated in 25-bit arithmetic so there is no wrap.
  - in_set: RGB = 24'h000000.
  - Otherwise: idx = iter_count >> COLOUR_SHIFT, saturated to 8'hFF if any higher bit is set.
    - R = idx
    - G = {idx[6:0],1'b0}
    - B = 8'hFF - idx
- Raster:
  - pix_x wraps from WIDTH-1 to 0, and pix_y increments on that wrap.
  - Each FIFO entry stores {tuser, tlast, rgb}:
    - tuser = (x = 0 and y = 0)
    - tlast = (x = WIDTH-1)
  - x/y are the coordinates of the captured pixel, i.e. the values before the advance.
- FIFO/AXI:
  - The FIFO is synchronous, first-word-fall-through, and FIFO_DEPTH entries of 26 bits.
  - A pop occurs on tvalid & tready.
  - Simultaneous push and pop are allowed when full: a pop in the same cycle does NOT free space for that cycle's push. The full flag is the registered value, so HOLD waits one extra cycle.
  - tdata, tlast and tuser stay stable while tvalid & !tready.
  - No entry is ever dropped or duplicated.
- Frame flow control: start pulses during RUN, HOLD or CLEAR are ignored. The FIFO may still hold pixels in IDLE; draining continues there.

Decomposition:
- Shared package:
  - state encoding (IDLE, RUN, HOLD, CLEAR)
  - ITER_STEP = 24'd4, shared with the counter stage
  - RGB_W = 24
  - FIFO entry width
- One sub-module: pixel_out_fifo, a parameterised FWFT synchronous FIFO with full/empty flags and synchronous active-high flush.
- Colour mapping stays inline in the top level as combinational logic.

Test Plan:
1. WIDTH=4, HEIGHT=2, tready=1, start; iter_done after 3 cycles per pixel with iter_count=40, max=100 → 8 beats. tuser only on beat 0; tlast on beats 3 and 7; each RGB = 24'h0A14F5; frame_done pulses once; then IDLE with clr=1.
2. iter_count=98, max=100 → in_set, tdata=24'h000000. iter_count=96 → tdata=24'h1830E7.
3. iter_count=24'h000800, max=24'hFFFFFF → idx saturates: tdata=24'hFFFEFF... no, 8'hFF gives R=FF, G=FE, B=00, so tdata=24'hFFFE00.
4. FIFO_DEPTH=4, tready=0, 6 pixels done → state enters HOLD on pixel 5 with clr=0 and pix_x frozen. Raising tready drains beats in order, pixel 5 is written, and no loss or duplication occurs.
5. Assert aresetn mid-frame with 3 FIFO entries → next cycle tvalid=0, clr=1, pix_x=pix_y=0, busy=0. A subsequent start restarts at tuser=1.
6. Pulse start while busy → ignored: pixel sequence and coordinates are unchanged, and exactly one frame_done is produced.
